crossbar_ingress: RTL and testbench
===================================

CROSSBAR_INGRESS -- requirements
Module: crossbar_ingress

Interface
REQ-001 Parameter M, default 4, SHALL set the number of crossbar output ports addressable by dest.
REQ-002 Parameter DW, default 32, SHALL set the data word width.
REQ-003 Parameter DEPTH, default 4 (power of two, >=2), SHALL set the entry count of the ingress queue.
REQ-004 Parameter STARVE_LIMIT, default 8 (>=2), SHALL set the number of consecutive ungranted request cycles before backoff.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  upstream word valid.
REQ-008 in_ready  output  1  queue can accept a word.
REQ-009 in_data  input  DW  upstream payload.
REQ-010 in_dest  input  $clog2(M)  upstream destination port index.
REQ-011 req  output  1  request toward crossbar arbiter.
REQ-012 dest  output  $clog2(M)  destination of head entry.
REQ-013 data  output  DW  payload of head entry.
REQ-014 grant  input  1  crossbar grant for this port.
REQ-015 starve  output  1  one-cycle pulse on entry to BACKOFF.

Function
REQ-016 Push SHALL occur on a clk edge with in_valid && in_ready; in_ready SHALL equal !full, derived from registered count only.
REQ-017 Transfer SHALL occur on a clk edge with req && grant; the head entry SHALL be popped on that edge.
REQ-018 dest and data SHALL show the head entry and SHALL stay stable while req is high and no transfer has occurred.
REQ-019 FSM states SHALL be IDLE, REQ and BACKOFF; req SHALL be high only in REQ.
REQ-020 IDLE->REQ SHALL occur on the edge after the queue becomes non-empty, giving one-cycle latency from push to req.
REQ-021 REQ->IDLE SHALL occur on a transfer that empties the queue; REQ SHALL persist on a transfer that leaves entries, giving back-to-back transfers.
REQ-022 The wait counter SHALL count REQ cycles without grant, clear on transfer, and on reaching STARVE_LIMIT-1 without grant SHALL move the FSM to BACKOFF and pulse starve.
REQ-023 BACKOFF SHALL last exactly one cycle, then return to REQ with the same head entry; grant SHALL be ignored in IDLE and BACKOFF.
REQ-024 Simultaneous push and transfer SHALL leave count unchanged. Push to an empty queue SHALL not produce req in the same cycle.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; count SHALL span 0..DEPTH.

Reset
REQ-026 Asserting rst_n low SHALL immediately force state IDLE, count/pointers/wait counter 0, req 0, starve 0, in_ready 1, dest 0, data 0, discarding queued entries, including mid-request.
REQ-027 The first push SHALL be accepted on the first clk edge with rst_n high.

Configuration
REQ-028 With XBAR_INGRESS_STATS_EN defined, outputs sent_cnt[31:0] (transfers) and stall_cnt[31:0] (ungranted REQ cycles) SHALL exist, wrap at 2^32 and reset to 0; without it these ports and counters SHALL be absent and all other behaviour identical.

Structure
REQ-029 A shared package xbar_pkg SHALL hold the FSM state enum (IDLE, REQ, BACKOFF) and the default width constants.
REQ-030 The queue SHALL be a sub-module xbar_ingress_fifo (storage, pointers, count, full, empty).

Verification (M=4, DW=32, DEPTH=4, STARVE_LIMIT=8)
REQ-031 Push A1A1A1A1 dest 2 with grant tied high: req rises 1 cycle after push, transfer next edge, then IDLE, in_ready 1.
REQ-032 Push 4 words with grant low: in_ready 0 after fourth push, fifth in_valid not accepted, count 4.
REQ-033 Grant low for 8 REQ cycles: starve pulses once, req low 1 cycle, req returns with unchanged dest/data.
REQ-034 Queue full, grant high, in_valid high every cycle: words DEADBEEF, CAFEBABE, 12345678, 87654321 appear in order, one per cycle, no loss or duplication.
REQ-035 rst_n pulled low mid-REQ with 3 entries queued: req 0 and in_ready 1 immediately; no stale word appears after release.
REQ-036 With XBAR_INGRESS_STATS_EN defined, after REQ-033 followed by one grant: sent_cnt 1, stall_cnt 8.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar ingress slice: FSM state encoding and
// default widths used by crossbar_ingress and xbar_ingress_fifo.
package xbar_pkg;

  localparam int DEFAULT_M            = 4;
  localparam int DEFAULT_DW           = 32;
  localparam int DEFAULT_DEPTH        = 4;
  localparam int DEFAULT_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    BACKOFF = 2'd2
  } xbar_state_t;

endpackage : xbar_pkg

// File: rtl/xbar_ingress_fifo.sv
// Ingress queue for crossbar_ingress: circular buffer with read/write
// pointers that wrap modulo DEPTH and an occupancy count spanning 0..DEPTH.
// The head word reads as zero while the queue is empty, so nothing stale
// from before a reset can ever leak out.
module xbar_ingress_fifo
  import xbar_pkg::*;
#(
  parameter int W     = DEFAULT_DW,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // storage write; contents need no reset because reads are gated by empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // pointers and occupancy; a simultaneous push and pop leaves count as is
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // status flags from the registered count, head word masked when empty
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    rd_data = empty ? '0 : mem[rd_ptr];
  end

endmodule : xbar_ingress_fifo

// File: rtl/crossbar_ingress.sv
// Crossbar ingress port: queues upstream words and requests the crossbar
// arbiter for the head entry. A port left ungranted for STARVE_LIMIT request
// cycles drops its request for one BACKOFF cycle and pulses starve.
// Optional build macro XBAR_INGRESS_STATS_EN adds sent_cnt / stall_cnt.
module crossbar_ingress
  import xbar_pkg::*;
#(
  parameter int M            = DEFAULT_M,
  parameter int DW           = DEFAULT_DW,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  localparam int DESTW       = (M > 1) ? $clog2(M) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [DESTW-1:0] in_dest,
  output logic             req,
  output logic [DESTW-1:0] dest,
  output logic [DW-1:0]    data,
  input  logic             grant,
  output logic             starve
`ifdef XBAR_INGRESS_STATS_EN
  ,
  output logic [31:0]      sent_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int WCW = $clog2(STARVE_LIMIT);

  xbar_state_t     state;
  xbar_state_t     next_state;
  logic [WCW-1:0]  wait_cnt;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            xfer;
  logic            wait_expired;

  // handshake qualifiers: accept when not full, transfer when granted in REQ
  always_comb begin
    in_ready     = !fifo_full;
    push         = in_valid && !fifo_full;
    xfer         = req && grant;
    wait_expired = (wait_cnt == WCW'(STARVE_LIMIT - 1));
  end

  xbar_ingress_fifo #(
    .W     (DESTW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data ({in_dest, in_data}),
    .pop     (xfer),
    .rd_data ({dest, data}),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next state: request once the queue holds data, back off after a long wait
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          next_state = REQ;
        end
      end
      REQ: begin
        if (xfer) begin
          if (fifo_count == CW'(1) && !push) begin
            next_state = IDLE;
          end
        end else if (wait_expired) begin
          next_state = BACKOFF;
        end
      end
      BACKOFF: begin
        next_state = REQ;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // outputs: request only in REQ, starve marks the single BACKOFF cycle
  always_comb begin
    req    = 1'b0;
    starve = 1'b0;
    unique case (state)
      REQ:     req    = 1'b1;
      BACKOFF: starve = 1'b1;
      default: ;
    endcase
  end

  // count consecutive ungranted REQ cycles; any other cycle restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == REQ && !grant && !wait_expired) begin
      wait_cnt <= wait_cnt + WCW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef XBAR_INGRESS_STATS_EN
  // free-running transfer and stall counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (xfer) begin
        sent_cnt <= sent_cnt + 32'd1;
      end
      if (req && !grant) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`else
  // statistics counters are not built in this configuration
`endif

endmodule : crossbar_ingress

// File: tb/tb_crossbar_ingress.sv
// Directed bench for crossbar_ingress (M=4, DW=32, DEPTH=4, STARVE_LIMIT=8).
// Build with XBAR_INGRESS_STATS_EN defined to also cover the stats counters.
module tb_crossbar_ingress;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_dest;
  logic        req;
  logic [1:0]  dest;
  logic [31:0] data;
  logic        grant;
  logic        starve;
`ifdef XBAR_INGRESS_STATS_EN
  logic [31:0] sent_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_compared;
  int n_mismatched;

  typedef struct {
    logic        in_valid;
    logic [31:0] in_data;
    logic [1:0]  in_dest;
    logic        grant;
    logic        exp_ready;
    logic        exp_req;
    logic        exp_starve;
    logic [1:0]  exp_dest;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [20];

  crossbar_ingress #(
    .M            (4),
    .DW           (32),
    .DEPTH        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .req      (req),
    .dest     (dest),
    .data     (data),
    .grant    (grant),
    .starve   (starve)
`ifdef XBAR_INGRESS_STATS_EN
    ,
    .sent_cnt (sent_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  // free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic [1:0] ds, input logic g);
    in_valid = v;
    in_data  = d;
    in_dest  = ds;
    grant    = g;
  endtask

  task automatic check_port(input string tag, input logic rdy, input logic rq, input logic st,
                            input logic [1:0] ds, input logic [31:0] dt);
    check_output({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    check_output({tag, " req"},      {31'd0, req},      {31'd0, rq});
    check_output({tag, " starve"},   {31'd0, starve},   {31'd0, st});
    check_output({tag, " dest"},     {30'd0, dest},     {30'd0, ds});
    check_output({tag, " data"},     data,              dt);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] stream_in  [4];
    logic [31:0] stream_out [7];

    n_compared   = 0;
    n_mismatched = 0;
    rst_n = 1'b0;
    apply_stimulus(1'b0, 32'h0, 2'd0, 1'b0);

    // valid, data, dest, grant | ready, req, starve, dest, data
    vecs[0]  = '{1'b1, 32'hA1A1A1A1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00000000};
    vecs[1]  = '{1'b0, 32'h00000000, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'hA1A1A1A1};
    vecs[2]  = '{1'b0, 32'h00000000, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 32'hA1A1A1A1};
    vecs[3]  = '{1'b0, 32'h00000000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00000000};
    vecs[4]  = '{1'b1, 32'h11111111, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00000000};
    vecs[5]  = '{1'b1, 32'h22222222, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h11111111};
    vecs[6]  = '{1'b1, 32'h33333333, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h11111111};
    vecs[7]  = '{1'b1, 32'h44444444, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h11111111};
    vecs[8]  = '{1'b1, 32'h55555555, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h11111111};
    vecs[9]  = '{1'b0, 32'h00000000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h11111111};
    vecs[10] = '{1'b0, 32'h00000000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h11111111};
    vecs[11] = '{1'b0, 32'h00000000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h11111111};
    vecs[12] = '{1'b0, 32'h00000000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h11111111};
    vecs[13] = '{1'b0, 32'h00000000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h11111111};
    vecs[14] = '{1'b0, 32'h00000000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h11111111};
    vecs[15] = '{1'b0, 32'h00000000, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h11111111};
    vecs[16] = '{1'b0, 32'h00000000, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 32'h22222222};
    vecs[17] = '{1'b0, 32'h00000000, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 32'h33333333};
    vecs[18] = '{1'b0, 32'h00000000, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 32'h44444444};
    vecs[19] = '{1'b0, 32'h00000000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00000000};

    stream_in[0]  = 32'h0F000001;
    stream_in[1]  = 32'h0F000001;
    stream_in[2]  = 32'h0F000002;
    stream_in[3]  = 32'h0F000003;
    stream_out[0] = 32'hDEADBEEF;
    stream_out[1] = 32'hCAFEBABE;
    stream_out[2] = 32'h12345678;
    stream_out[3] = 32'h87654321;
    stream_out[4] = 32'h0F000001;
    stream_out[5] = 32'h0F000002;
    stream_out[6] = 32'h0F000003;

    // reset state while rst_n is held low
    #2;
    check_port("reset", 1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
`ifdef XBAR_INGRESS_STATS_EN
    check_output("reset sent_cnt", sent_cnt, 32'd0);
    check_output("reset stall_cnt", stall_cnt, 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single transfer, fill to full, starvation backoff, drain
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(vecs[i].in_valid, vecs[i].in_data, vecs[i].in_dest, vecs[i].grant);
      check_port($sformatf("v%0d", i), vecs[i].exp_ready, vecs[i].exp_req,
                 vecs[i].exp_starve, vecs[i].exp_dest, vecs[i].exp_data);
`ifdef XBAR_INGRESS_STATS_EN
      if (i == 16) begin
        check_output("stats sent_cnt", sent_cnt, 32'd1);
        check_output("stats stall_cnt", stall_cnt, 32'd8);
      end
`endif
      next_cycle();
    end

    // fill the queue with grant low, then stream with grant high
    apply_stimulus(1'b1, 32'hDEADBEEF, 2'd0, 1'b0);
    next_cycle();
    apply_stimulus(1'b1, 32'hCAFEBABE, 2'd0, 1'b0);
    next_cycle();
    apply_stimulus(1'b1, 32'h12345678, 2'd0, 1'b0);
    next_cycle();
    apply_stimulus(1'b1, 32'h87654321, 2'd0, 1'b0);
    next_cycle();
    check_output("full in_ready", {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        apply_stimulus(1'b1, stream_in[c], 2'd0, 1'b1);
      end else begin
        apply_stimulus(1'b0, 32'h0, 2'd0, 1'b1);
      end
      check_output($sformatf("stream%0d req", c), {31'd0, req}, 32'd1);
      check_output($sformatf("stream%0d data", c), data, stream_out[c]);
      next_cycle();
    end
    apply_stimulus(1'b0, 32'h0, 2'd0, 1'b0);
    check_output("stream end req", {31'd0, req}, 32'd0);
    check_output("stream end data", data, 32'h0);
    next_cycle();

    // reset in the middle of a request with three entries queued
    apply_stimulus(1'b1, 32'h0BAD0001, 2'd1, 1'b0);
    next_cycle();
    apply_stimulus(1'b1, 32'h0BAD0002, 2'd2, 1'b0);
    next_cycle();
    apply_stimulus(1'b1, 32'h0BAD0003, 2'd3, 1'b0);
    next_cycle();
    apply_stimulus(1'b0, 32'h0, 2'd0, 1'b0);
    check_output("midreq req", {31'd0, req}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_port("async reset", 1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b1, 32'h5A5A5A5A, 2'd1, 1'b1);
    next_cycle();
    apply_stimulus(1'b0, 32'h0, 2'd0, 1'b1);
    check_port("post reset push", 1'b1, 1'b0, 1'b0, 2'd1, 32'h5A5A5A5A);
    next_cycle();
    check_port("post reset req", 1'b1, 1'b1, 1'b0, 2'd1, 32'h5A5A5A5A);
    next_cycle();
    check_port("post reset idle", 1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
`ifdef XBAR_INGRESS_STATS_EN
    check_output("post reset sent_cnt", sent_cnt, 32'd1);
    check_output("post reset stall_cnt", stall_cnt, 32'd0);
`endif
    next_cycle();
    check_port("no stale word", 1'b1, 1'b0, 1'b0, 2'd0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_crossbar_ingress
